// File: rtl/denise_pkg.sv
// Shared constants for the Denise sprite blocks: register map of the SPRxPOS/CTL/DATA/DATB
// group and sprite pixel geometry.
package denise_pkg;

  localparam logic [8:0]  SPRPOS_BASE   = 9'h140;
  localparam int unsigned SPR_STRIDE    = 8;
  localparam logic [8:0]  SPR_OFS_POS   = 9'd0;
  localparam logic [8:0]  SPR_OFS_CTL   = 9'd2;
  localparam logic [8:0]  SPR_OFS_DATA  = 9'd4;
  localparam logic [8:0]  SPR_OFS_DATB  = 9'd6;
  localparam int          SPR_PIX_W     = 2;
  localparam int          SPR_WORD_W    = 16;
  localparam logic [4:0]  SPR_BURST_LEN = 5'd16;

  typedef enum logic [1:0] {
    REG_POS,
    REG_CTL,
    REG_DATA,
    REG_DATB
  } spr_reg_e;

  // Word address (bits [8:1] of the byte address) of one register of sprite n.
  function automatic logic [7:0] spr_reg_addr(input int unsigned sprite, input spr_reg_e reg_sel);
    logic [8:0] ofs;
    logic [8:0] byte_addr;
    ofs = SPR_OFS_POS;
    case (reg_sel)
      REG_POS:  ofs = SPR_OFS_POS;
      REG_CTL:  ofs = SPR_OFS_CTL;
      REG_DATA: ofs = SPR_OFS_DATA;
      REG_DATB: ofs = SPR_OFS_DATB;
      default:  ofs = SPR_OFS_POS;
    endcase
    byte_addr = SPRPOS_BASE + 9'(sprite * SPR_STRIDE) + ofs;
    return byte_addr[8:1];
  endfunction

endpackage

// File: rtl/denise_sprite_shifter.sv
// One sprite: POS/CTL/DATA/DATB capture, arm flag, horizontal start compare and the
// 16-pixel A/B shifters with their pixel counter.
module denise_sprite_shifter
  import denise_pkg::*;
#(
  parameter int unsigned SPRITE = 0,
  parameter int          HBITS  = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk7_en,
  input  logic [7:0]           reg_address_in,
  input  logic [15:0]          data_in,
  input  logic [HBITS-1:0]     hpos,
  output logic [SPR_PIX_W-1:0] pixel,
  output logic                 active
);

  localparam logic [7:0] ADDR_POS  = spr_reg_addr(SPRITE, REG_POS);
  localparam logic [7:0] ADDR_CTL  = spr_reg_addr(SPRITE, REG_CTL);
  localparam logic [7:0] ADDR_DATA = spr_reg_addr(SPRITE, REG_DATA);
  localparam logic [7:0] ADDR_DATB = spr_reg_addr(SPRITE, REG_DATB);

  logic [8:0]            hstart;
  logic                  armed;
  logic [SPR_WORD_W-1:0] hold_a, hold_b;
  logic [SPR_WORD_W-1:0] sh_a, sh_b;
  logic [4:0]            count;

  logic wr_pos, wr_ctl, wr_data, wr_datb, trigger;

  assign wr_pos  = (reg_address_in == ADDR_POS);
  assign wr_ctl  = (reg_address_in == ADDR_CTL);
  assign wr_data = (reg_address_in == ADDR_DATA);
  assign wr_datb = (reg_address_in == ADDR_DATB);

  // A CTL write in the match cycle disarms and suppresses the load.
  assign trigger = armed && (hpos == HBITS'(hstart)) && !wr_ctl;

  assign active = (count != 5'd0);
  assign pixel  = active ? {sh_b[SPR_WORD_W-1], sh_a[SPR_WORD_W-1]} : '0;

  // NOTE: every flop, hold words included, is cleared by reset so a sprite cannot fire
  // from stale data; all state uses non-blocking assignments so the match sees pre-edge
  // armed/hold values (a same-cycle DATA write arms only from the next cycle on).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hstart <= '0;
      armed  <= 1'b0;
      hold_a <= '0;
      hold_b <= '0;
      sh_a   <= '0;
      sh_b   <= '0;
      count  <= '0;
    end else if (clk7_en) begin
      if (wr_pos) hstart[8:1] <= data_in[7:0];
      if (wr_ctl) begin
        hstart[0] <= data_in[0];
        armed     <= 1'b0;
      end
      if (wr_data) begin
        hold_a <= data_in;
        armed  <= 1'b1;
      end
      if (wr_datb) hold_b <= data_in;

      if (trigger) begin
        sh_a  <= hold_a;
        sh_b  <= hold_b;
        count <= SPR_BURST_LEN;
      end else if (active) begin
        sh_a  <= sh_a << 1;
        sh_b  <= sh_b << 1;
        count <= count - 5'd1;
      end
    end
  end

endmodule

// File: rtl/denise_sprite_pair.sv
// Sprite pair 2*PAIR / 2*PAIR+1 serializer. Define DENISE_SPRITE_ATTACH_EN to latch the
// odd sprite's attach bit and blank sprdata1 while both attached sprites overlap.
module denise_sprite_pair
  import denise_pkg::*;
#(
  parameter int unsigned PAIR  = 0,
  parameter int          HBITS = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk7_en,
  input  logic [7:0]           reg_address_in,
  input  logic [15:0]          data_in,
  input  logic [HBITS-1:0]     hpos,
  output logic [1:0]           nsprite,
  output logic [SPR_PIX_W-1:0] sprdata0,
  output logic [SPR_PIX_W-1:0] sprdata1,
  output logic                 attached
);

  logic [SPR_PIX_W-1:0] pix0, pix1;
  logic                 active0, active1;

  denise_sprite_shifter #(.SPRITE(2 * PAIR), .HBITS(HBITS)) u_even (
    .clk            (clk),
    .reset          (reset),
    .clk7_en        (clk7_en),
    .reg_address_in (reg_address_in),
    .data_in        (data_in),
    .hpos           (hpos),
    .pixel          (pix0),
    .active         (active0)
  );

  denise_sprite_shifter #(.SPRITE(2 * PAIR + 1), .HBITS(HBITS)) u_odd (
    .clk            (clk),
    .reset          (reset),
    .clk7_en        (clk7_en),
    .reg_address_in (reg_address_in),
    .data_in        (data_in),
    .hpos           (hpos),
    .pixel          (pix1),
    .active         (active1)
  );

  // Collision inputs always see the raw pixels, even when sprdata1 is blanked.
  assign nsprite  = {|pix1, |pix0};
  assign sprdata0 = pix0;

`ifdef DENISE_SPRITE_ATTACH_EN
  localparam logic [7:0] ADDR_ODD_CTL = spr_reg_addr(2 * PAIR + 1, REG_CTL);

  logic attach_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attach_q <= 1'b0;
    end else if (clk7_en && (reg_address_in == ADDR_ODD_CTL)) begin
      attach_q <= data_in[7];
    end
  end

  assign attached = attach_q;
  assign sprdata1 = (attach_q && active0 && active1) ? '0 : pix1;
`else
  assign attached = 1'b0;
  assign sprdata1 = pix1;
`endif

endmodule

// File: tb/tb_denise_sprite_pair.sv
// Self-checking bench for denise_sprite_pair (PAIR=1): directed scenarios plus random bus
// traffic, all compared every cycle against a pixel-index model of each sprite.
module tb_denise_sprite_pair;

  localparam int PAIR  = 1;
  localparam int HBITS = 9;
  localparam int LINE  = 228;

  // Word addresses for sprites 2 and 3: byte 0x150.. and 0x158.., halved.
  localparam logic [7:0] A2POS  = 8'hA8;
  localparam logic [7:0] A2CTL  = 8'hA9;
  localparam logic [7:0] A2DATA = 8'hAA;
  localparam logic [7:0] A2DATB = 8'hAB;
  localparam logic [7:0] A3POS  = 8'hAC;
  localparam logic [7:0] A3CTL  = 8'hAD;
  localparam logic [7:0] A3DATA = 8'hAE;
  localparam logic [7:0] A3DATB = 8'hAF;
  localparam logic [7:0] AIDLE  = 8'h00;

  logic             clk = 1'b0;
  logic             reset;
  logic             clk7_en;
  logic [7:0]       reg_address_in;
  logic [15:0]      data_in;
  logic [HBITS-1:0] hpos;
  logic [1:0]       nsprite, sprdata0, sprdata1;
  logic             attached;

  denise_sprite_pair #(.PAIR(PAIR), .HBITS(HBITS)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk7_en        (clk7_en),
    .reg_address_in (reg_address_in),
    .data_in        (data_in),
    .hpos           (hpos),
    .nsprite        (nsprite),
    .sprdata0       (sprdata0),
    .sprdata1       (sprdata1),
    .attached       (attached)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int hpos_v   = 0;
  int cnt_nz0  = 0;
  int cnt_nz1  = 0;

  // Model: per sprite, registers plus captured words and the index (1..16) of the pixel
  // currently displayed, 0 when idle.
  logic [8:0]  m_hstart [2];
  logic [15:0] m_hold_a [2];
  logic [15:0] m_hold_b [2];
  logic [15:0] m_cap_a  [2];
  logic [15:0] m_cap_b  [2];
  bit          m_armed  [2];
  int          m_p      [2];
  bit          m_attach;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hstart[k] = '0; m_hold_a[k] = '0; m_hold_b[k] = '0;
      m_cap_a[k] = '0; m_cap_b[k] = '0; m_armed[k] = 0; m_p[k] = 0;
    end
    m_attach = 0;
  endtask

  function automatic logic [1:0] exp_pix(input int k);
    if (m_p[k] == 0) return 2'b00;
    return {m_cap_b[k][16 - m_p[k]], m_cap_a[k][16 - m_p[k]]};
  endfunction

  task automatic model_step(input bit en, input logic [7:0] addr, input logic [15:0] data,
                            input int hp);
    logic [7:0] base;
    bit hit;
    if (!en) return;
    for (int k = 0; k < 2; k++) begin
      base = 8'hA8 + 8'(4 * k);
      hit = m_armed[k] && (hp == int'(m_hstart[k])) && (addr != base + 8'd1);
      if (hit) begin
        m_cap_a[k] = m_hold_a[k];
        m_cap_b[k] = m_hold_b[k];
        m_p[k] = 1;
      end else if (m_p[k] != 0) begin
        m_p[k] = (m_p[k] == 16) ? 0 : m_p[k] + 1;
      end
      if (addr == base)         m_hstart[k] = {data[7:0], m_hstart[k][0]};
      if (addr == base + 8'd1) begin m_hstart[k][0] = data[0]; m_armed[k] = 0; end
      if (addr == base + 8'd2) begin m_hold_a[k] = data; m_armed[k] = 1; end
      if (addr == base + 8'd3)  m_hold_b[k] = data;
    end
    if (addr == A3CTL) m_attach = data[7];
  endtask

  task automatic compare();
    logic [1:0] p0, p1, s1;
    bit att;
    p0 = exp_pix(0);
    p1 = exp_pix(1);
`ifdef DENISE_SPRITE_ATTACH_EN
    att = m_attach;
    s1 = (m_attach && m_p[0] != 0 && m_p[1] != 0) ? 2'b00 : p1;
`else
    att = 0;
    s1 = p1;
`endif
    check("sprdata0", 16'(sprdata0), 16'(p0));
    check("sprdata1", 16'(sprdata1), 16'(s1));
    check("nsprite", 16'(nsprite), 16'({|p1, |p0}));
    check("attached", 16'(attached), 16'(att));
    if (nsprite[0]) cnt_nz0++;
    if (nsprite[1]) cnt_nz1++;
  endtask

  // One clock: drive inputs just after a falling edge, model the rising edge, compare at
  // the following falling edge.
  task automatic cycle(input bit en, input logic [7:0] addr, input logic [15:0] data);
    clk7_en = en;
    reg_address_in = addr;
    data_in = data;
    hpos = HBITS'(hpos_v);
    model_step(en, addr, data, hpos_v);
    if (en) hpos_v = (hpos_v == LINE - 1) ? 0 : hpos_v + 1;
    @(negedge clk);
    compare();
  endtask

  task automatic wr(input logic [7:0] addr, input logic [15:0] data);
    cycle(1'b1, addr, data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, AIDLE, 16'h0000);
  endtask

  task automatic run_to(input int target);
    for (int guard = 0; guard < LINE + 2 && hpos_v != target; guard++) idle(1);
    check("run_to_hpos", 16'(hpos_v), 16'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] want;
    logic [7:0] a;
    logic [15:0] d;
    bit en;

    reset = 1'b1; clk7_en = 1'b0; reg_address_in = AIDLE; data_in = '0; hpos = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_nsprite", 16'(nsprite), 16'h0);
    check("reset_sprdata0", 16'(sprdata0), 16'h0);
    check("reset_sprdata1", 16'(sprdata1), 16'h0);
    check("reset_attached", 16'(attached), 16'h0);
    reset = 1'b0;

    // 1: four-pixel burst at hpos 0x80, first pixel one enable after the match.
    wr(A2POS, 16'h0040); wr(A2CTL, 16'h0000); wr(A2DATB, 16'h0000); wr(A2DATA, 16'hF000);
    run_to(9'h080);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      want = (i < 4) ? 2'b01 : 2'b00;
      check("s1_pix", 16'(sprdata0), 16'(want));
      check("s1_nspr0", 16'(nsprite[0]), 16'(want[0]));
    end

    // 2: CTL mid-burst lets the burst finish, then the sprite stays quiet.
    wr(A2DATA, 16'hFFFF);
    run_to(9'h080);
    cnt_nz0 = 0;
    idle(6);
    wr(A2CTL, 16'h0000);
    idle(30);
    check("s2_burst_len", 16'(cnt_nz0), 16'd16);
    cnt_nz0 = 0;
    idle(LINE);
    check("s2_disarmed", 16'(cnt_nz0), 16'd0);

    // 3: first and last pixel from the end bits of the data words.
    wr(A2DATB, 16'h8000); wr(A2DATA, 16'h8001);
    run_to(9'h080);
    for (int i = 0; i < 18; i++) begin
      idle(1);
      want = (i == 0) ? 2'b11 : (i == 15) ? 2'b01 : 2'b00;
      check("s3_pix", 16'(sprdata0), 16'(want));
    end

    // 4: a second match 8 pixels in restarts the burst: 8 + 16 lit pixels.
    wr(A2DATB, 16'h0000); wr(A2DATA, 16'hFFFF);
    run_to(9'h080);
    cnt_nz0 = 0;
    idle(6);
    wr(A2POS, 16'h0044);
    idle(40);
    check("s4_restart", 16'(cnt_nz0), 16'd24);

    // 5: asynchronous reset mid-burst, then nothing fires without a new DATA write.
    run_to(9'h088);
    idle(4);
    check("s5_busy", 16'(sprdata0), 16'(2'b01));
    #2 reset = 1'b1;
    #1;
    check("s5_rst_nspr", 16'(nsprite), 16'h0);
    check("s5_rst_spr0", 16'(sprdata0), 16'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cnt_nz0 = 0; cnt_nz1 = 0;
    idle(2 * LINE);
    check("s5_quiet0", 16'(cnt_nz0), 16'd0);
    check("s5_quiet1", 16'(cnt_nz1), 16'd0);

    // 6: both sprites at the same start with the odd attach bit set.
    wr(A2POS, 16'h0040); wr(A2CTL, 16'h0000); wr(A2DATB, 16'h0000); wr(A2DATA, 16'hFFFF);
    wr(A3POS, 16'h0040); wr(A3CTL, 16'h0080); wr(A3DATB, 16'h0000); wr(A3DATA, 16'hFFFF);
    run_to(9'h080);
    idle(1);
    check("s6_nsprite", 16'(nsprite), 16'(2'b11));
    check("s6_spr0", 16'(sprdata0), 16'(2'b01));
`ifdef DENISE_SPRITE_ATTACH_EN
    check("s6_attached", 16'(attached), 16'h1);
    check("s6_spr1", 16'(sprdata1), 16'h0);
`else
    check("s6_attached", 16'(attached), 16'h0);
    check("s6_spr1", 16'(sprdata1), 16'(2'b01));
`endif
    idle(20);

    // Random traffic with gapped enables; every cycle compared against the model.
    for (int i = 0; i < 5000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 80) a = AIDLE;
      else if ($urandom_range(0, 9) != 0) a = 8'hA8 + 8'($urandom_range(0, 7));
      else a = 8'($urandom);
      d = 16'($urandom);
      if (a == A2POS || a == A3POS) d[7:0] = 8'($urandom_range(0, 127));
      cycle(en, a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/denise_sprite_pair.md
Name: denise_sprite_pair

Overview:
- Sprite serializer for one OCS sprite pair (sprites 2P and 2P+1).
- Captures SPRxPOS/CTL/DATA/DATB writes from the chip register bus and compares the horizontal beam position against each sprite's start.
- Shifts out 2-bit sprite pixels on each match.
- Its nsprite[1:0] outputs drive the collision detector's sprite inputs; its pixel outputs drive the sprite priority/colour mux.

Parameters:
- PAIR, 0, pair index 0..3. Sprite n = 2*PAIR+k (k = 0 or 1) uses register base 9'h140 + n*8.
- HBITS, 9, width of horizontal position compare.

Ports:
- clk  in  1  28MHz clock
- reset  in  1  asynchronous, active-high reset
- clk7_en  in  1  pixel-rate enable; all state advances only when high
- reg_address_in  in  8  register address [8:1]
- data_in  in  16  register write data
- hpos  in  HBITS  current lores horizontal beam position
- nsprite  out  2  [k] = sprite k pixel non-transparent
- sprdata0  out  2  sprite 2P pixel {B,A}
- sprdata1  out  2  sprite 2P+1 pixel {B,A}
- attached  out  1  attach bit of odd sprite, latched from CTL bit 7

Behaviour:
- Register decode, sprite k, base = 9'h140 + (2*PAIR+k)*8:
  - POS (+0): hstart[8:1] <= data_in[7:0].
  - CTL (+2): hstart[0] <= data_in[0]; attach <= data_in[7] (odd sprite only); disarm.
  - DATA (+4): holdA <= data_in; arm.
  - DATB (+6): holdB <= data_in.
- The block is write-only and has no data_out.
- Per-sprite state: armed flag, shA/shB 16-bit shift registers, 5-bit count.
- Pipeline timing: match on cycle t loads the shifters at the t clock edge. The first pixel appears at cycle t+1. The last pixel appears at t+16. Outputs return to 0 at t+17.
- Shifting:
  - Each clk7_en with count != 0: shA <= shA<<1, shB <= shB<<1, count--.
  - Pixel = {shB[15], shA[15]} while count != 0, else 2'b00.
- Trigger: armed && hpos == hstart with clk7_en → shA <= holdA, shB <= holdB, count <= 16.
  - Armed persists after a trigger, so the sprite re-triggers every line until CTL is written.
- Simultaneous-event priorities:
  - Match while count != 0: reload wins and restarts at 16 (no merge).
  - DATA write in the same cycle as a match: the trigger uses the old holdA, and arming takes effect the next cycle.
  - CTL write in the same cycle as a match: the disarm wins and no load occurs. Shifting already in progress continues to completion.
- hpos wrap-around needs no special handling. Equality compare only; a start beyond the line length never matches.
- nsprite[k] = |sprdataK. This is purely combinational from the registered shifters/count, so there is no added latency.
- Reset: all registers, armed, count, attach clear to 0; every output is 0.
  - Reset asserted mid-shift aborts immediately, and outputs go 0 asynchronously.
- Between enables (clk7_en low), all state holds.

Optional Feature:
- Macro: DENISE_SPRITE_ATTACH_EN.
- Defined:
  - attached reflects the latched CTL bit 7 of the odd sprite.
  - sprdata1 is forced to 0 while attached and both sprites' counts are nonzero, so the colour mux uses the 4-bit {sprdata1,sprdata0} value.
  - nsprite is unchanged in both cases.
- Undefined:
  - attached is tied to 0 and the CTL bit 7 storage is omitted.
  - sprdata1 is never forced to 0.

Decomposition:
- Shared package denise_pkg: SPRPOS_BASE=9'h140, per-sprite register offsets, sprite pixel width constant.
- One natural sub-module, denise_sprite_shifter: a single sprite's hold registers, arm flag, compare, shifters and count. It is instantiated twice, with the attach/forcing logic in the parent.

Test Plan:
- PAIR=1:
  - Write SPR2POS=16'h0040, SPR2CTL=0, SPR2DATB=0, SPR2DATA=16'hF000.
  - Run hpos to 9'h080.
  - Expected: sprdata0=2'b01 and nsprite[0]=1 for exactly 4 pixels starting one enable after the match, then 0.
- Same setup, then write SPR2CTL mid-line.
  - Expected: the current 16-pixel burst completes, and the next line at hpos 9'h080 produces no output.
- Set DATA=16'h8001, DATB=16'h8000.
  - Expected: pixel 1 = 2'b11, pixels 2..15 = 0, pixel 16 = 2'b01.
- Issue a second match 8 pixels into a burst (change hstart via POS).
  - Expected: the burst restarts and 16 full pixels follow the second match.
- Assert reset during a burst.
  - Expected: nsprite=0 and sprdata=0 immediately.
  - With no new DATA write, nothing fires on later lines.
- With DENISE_SPRITE_ATTACH_EN defined: set SPR3CTL bit 7 and run both sprites at the same hstart.
  - Expected: attached=1, sprdata1 forced 0 during overlap.
  - Expected with the macro undefined: attached=0 and sprdata1 is not forced.
